// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and line-offset helper for the refill sequencer
package cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2, DONE = 2'd3} state_t;
  function automatic int off_w(int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: optional victim write-back then word-by-word line refill with ack timeout
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic [ADDR_W-1:0] cache_raddr,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_waddr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state
);
  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORDS_PER_LINE - 1);
  state_t st, nxt;
  logic [OFF_W-1:0] cnt;
  logic [TW-1:0] wcnt;
  logic [ADDR_W-1:0] line_base, vict_base, laddr, vaddr;
  logic active, ack, last, tmo;
  assign laddr = line_base | {{(ADDR_W-OFF_W){1'b0}}, cnt};
  assign vaddr = vict_base | {{(ADDR_W-OFF_W){1'b0}}, cnt};
  assign active = st == WRITEBACK || st == REFILL;
  assign ack = active && mem_ack;
  assign last = &cnt;
  assign tmo = TIMEOUT != 0 && active && !mem_ack && wcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      line_base <= '0;
      vict_base <= '0;
    end else begin
      st <= nxt;
      cnt <= st != nxt ? '0 : cnt + OFF_W'(ack);
      wcnt <= (st != nxt || ack || !active) ? '0 : wcnt + TW'(1);
      if (st == IDLE && miss) begin
        line_base <= miss_addr & ~OFF_MASK;
        vict_base <= victim_addr & ~OFF_MASK;
      end
    end
  end
  always_comb begin
    nxt = st;
    mem_req = active;
    mem_we = st == WRITEBACK;
    mem_addr = st == WRITEBACK ? vaddr : st == REFILL ? laddr : '0;
    cache_raddr = st == WRITEBACK ? vaddr : '0;
    mem_wdata = st == WRITEBACK ? cache_rdata : '0;
    cache_we = ack && st == REFILL;
    cache_waddr = cache_we ? laddr : '0;
    cache_wdata = cache_we ? mem_rdata : '0;
    busy = st != IDLE;
    done = st == DONE;
    err = tmo;
    state = st;
    case (st)
      IDLE:      nxt = miss ? (dirty ? WRITEBACK : REFILL) : IDLE;
      WRITEBACK: nxt = tmo ? IDLE : (ack && last) ? REFILL : WRITEBACK;
      REFILL:    nxt = tmo ? IDLE : (ack && last) ? DONE : REFILL;
      default:   nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: transaction-queue model checked every cycle plus directed literal checks
module tb_cache_refill_ctrl;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst = 0, miss = 0, dirty = 0, mem_ack = 0;
  logic [7:0] miss_addr = 0, victim_addr = 0, mem_rdata, cache_rdata;
  logic [7:0] cache_raddr, cache_waddr, cache_wdata, mem_addr, mem_wdata;
  logic cache_we, mem_req, mem_we, busy, done, err;
  logic [1:0] state;
  int checks = 0, errors = 0;

  cache_refill_ctrl #(.WORDS_PER_LINE(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .dirty(dirty),
    .victim_addr(victim_addr), .cache_raddr(cache_raddr), .cache_rdata(cache_rdata),
    .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err),
    .state(state));

  always #5 clk = ~clk;
  assign cache_rdata = cache_raddr ^ 8'h3C;
  assign mem_rdata = mem_addr ^ 8'hA5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory responder: 0 = ack every request cycle, 1 = every 3rd cycle, 2 = never
  int mode = 0, gap = 0;
  always @(posedge clk) begin
    #1;
    if (!mem_req) begin
      mem_ack = 0;
      gap = 0;
    end else begin
      mem_ack = mode == 0 ? 1'b1 : mode == 1 ? (gap == 2) : 1'b0;
      gap = mem_ack ? 0 : gap + 1;
    end
  end

  typedef struct packed {logic we; logic [7:0] addr;} xact_t;
  xact_t q[$];
  int mwait = 0;
  bit edone = 0, was_done;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      mwait = 0;
      edone = 0;
    end else begin
      was_done = edone;
      edone = 0;
      if (q.size() != 0) begin
        if (mem_ack) begin
          void'(q.pop_front());
          mwait = 0;
          if (q.size() == 0) edone = 1;
        end else if (mwait == TIMEOUT - 1) begin
          q.delete();
          mwait = 0;
        end else mwait++;
      end else if (!was_done && miss) begin
        if (dirty) for (int i = 0; i < 4; i++) q.push_back({1'b1, (victim_addr & 8'hFC) | 8'(i)});
        for (int i = 0; i < 4; i++) q.push_back({1'b0, (miss_addr & 8'hFC) | 8'(i)});
        mwait = 0;
      end
    end
  end

  xact_t h;
  bit act;
  always @(negedge clk) if (rst) begin
    act = q.size() != 0;
    h = act ? q[0] : '0;
    chk("busy", busy, act || edone);
    chk("done", done, edone);
    chk("state", state, edone ? 3 : !act ? 0 : h.we ? 1 : 2);
    chk("mem_req", mem_req, act);
    chk("err", err, act && mwait == TIMEOUT - 1 && !mem_ack);
    chk("cache_we", cache_we, act && !h.we && mem_ack);
    if (act) begin
      chk("mem_we", mem_we, h.we);
      chk("mem_addr", mem_addr, h.addr);
      if (h.we) begin
        chk("cache_raddr", cache_raddr, h.addr);
        chk("mem_wdata", mem_wdata, h.addr ^ 8'h3C);
      end else if (mem_ack) begin
        chk("cache_waddr", cache_waddr, h.addr);
        chk("cache_wdata", cache_wdata, h.addr ^ 8'hA5);
      end
    end
  end

  logic [8:0] log[$];
  int cyc = 0, cwe = 0, ndone = 0, nerr = 0, wt = 0, err_wait = 0, done_cyc = 0, ack_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (mem_req && mem_ack) begin
        log.push_back({mem_we, mem_addr});
        ack_cyc = cyc;
      end
      if (cache_we) cwe++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      wt = (!mem_req || mem_ack) ? 0 : wt + 1;
      if (err) begin
        nerr++;
        err_wait = wt;
        wt = 0;
      end
    end
  end

  task automatic clear_log();
    log.delete();
    cwe = 0;
    ndone = 0;
    nerr = 0;
  endtask

  task automatic do_miss(input logic [7:0] a, input logic d, input logic [7:0] v);
    @(posedge clk) #1;
    miss = 1;
    miss_addr = a;
    dirty = d;
    victim_addr = v;
    @(posedge clk) #1;
    miss = 0;
    dirty = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {cache_raddr, cache_waddr, cache_wdata, mem_addr}, 0);
    chk({tag, "_ctl"}, {cache_we, mem_req, mem_we, busy, done, err, state, mem_wdata}, 0);
  endtask

  task automatic chk_line(input string tag, input int first, input logic we, input logic [7:0] base);
    for (int i = 0; i < 4; i++) chk(tag, first + i < log.size() ? log[first + i] : 9'h1FF, {we, base + 8'(i)});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk) #1 rst = 1;

    clear_log();
    do_miss(8'h2D, 0, 8'h00);
    wait_idle();
    chk("t1_words", log.size(), 4);
    chk_line("t1_addr", 0, 0, 8'h2C);
    chk("t1_cwe", cwe, 4);
    chk("t1_done_lat", done_cyc - ack_cyc, 1);
    chk("t1_ndone", ndone, 1);

    clear_log();
    do_miss(8'h13, 1, 8'h41);
    wait_idle();
    chk("t2_words", log.size(), 8);
    chk_line("t2_wb", 0, 1, 8'h40);
    chk_line("t2_rf", 4, 0, 8'h10);
    chk("t2_cwe", cwe, 4);

    clear_log();
    mode = 1;
    do_miss(8'h77, 0, 8'h00);
    wait_idle();
    chk_line("t3_addr", 0, 0, 8'h74);
    chk("t3_cwe", cwe, 4);

    clear_log();
    mode = 2;
    do_miss(8'h88, 0, 8'h00);
    wait_idle();
    chk("t4_nerr", nerr, 1);
    chk("t4_wait", err_wait, 16);
    chk("t4_ndone", ndone, 0);
    chk("t4_cwe", cwe, 0);

    clear_log();
    mode = 0;
    do_miss(8'h34, 0, 8'h00);
    for (int n = 0; n < 50 && log.size() < 2; n++) @(negedge clk);
    chk("t5_pre", log.size(), 2);
    @(posedge clk) #2 rst = 0;
    #1 chk_zero("t5_async");
    @(posedge clk) #1 rst = 1;
    clear_log();
    do_miss(8'h56, 0, 8'h00);
    wait_idle();
    chk("t5_words", log.size(), 4);
    chk_line("t5_addr", 0, 0, 8'h54);

    clear_log();
    mode = 1;
    do_miss(8'h20, 0, 8'h00);
    repeat (3) @(posedge clk);
    do_miss(8'h80, 1, 8'hC0);
    begin
      int n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    miss = 1;
    miss_addr = 8'h90;
    @(posedge clk) #1 miss = 0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("t6_words", log.size(), 4);
    chk_line("t6_addr", 0, 0, 8'h20);
    chk("t6_cwe", cwe, 4);
    chk("t6_ndone", ndone, 1);
    chk("t6_idle", {busy, mem_req}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
